// File: rtl/aes_core_ctrl.sv
// aes_core_ctrl: valid/ready front end for an AES start/done core, one block in flight.
// Optional WAIT timeout is enabled by defining AES_CTRL_TIMEOUT_EN. When it is enabled,
// the TIMEOUT_CYC parameter also exists.
module aes_core_ctrl #(
  parameter int unsigned CNT_W       = 16
`ifdef AES_CTRL_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = 32
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [127:0]       s_data,
  input  logic               s_enc_dec,
  output logic               core_start,
  output logic               core_enc_dec,
  output logic [127:0]       core_data_in,
  input  logic [127:0]       core_data_out,
  input  logic               core_done,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [127:0]       m_data,
  output logic               m_err,
  output logic               busy,
  output logic [CNT_W-1:0]   blk_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  state_t state;

`ifdef AES_CTRL_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt;
`endif

  // Ready is decoded from state so it is high in the very first cycle after reset is released.
  assign s_ready = (state == ST_IDLE) && !reset;

`ifndef AES_CTRL_TIMEOUT_EN
  // Without the timeout, every result is a good core result.
  assign m_err = 1'b0;
`endif

  // Control FSM: accept, pulse start, wait for done, hold the result until it is taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      core_start   <= 1'b0;
      core_enc_dec <= 1'b0;
      core_data_in <= '0;
      m_valid      <= 1'b0;
      m_data       <= '0;
      busy         <= 1'b0;
      blk_count    <= '0;
`ifdef AES_CTRL_TIMEOUT_EN
      m_err        <= 1'b0;
      tmo_cnt      <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (s_valid) begin
            core_data_in <= s_data;
            core_enc_dec <= s_enc_dec;
            core_start   <= 1'b1;
            busy         <= 1'b1;
            state        <= ST_START;
          end
        end
        ST_START: begin
          // The start pulse lasts one cycle. A done pulse seen here is ignored.
          core_start <= 1'b0;
`ifdef AES_CTRL_TIMEOUT_EN
          tmo_cnt    <= '0;
`endif
          state      <= ST_WAIT;
        end
        ST_WAIT: begin
          // If done and the timeout land in the same cycle, the done result is used.
          if (core_done) begin
            m_data  <= core_data_out;
            m_valid <= 1'b1;
`ifdef AES_CTRL_TIMEOUT_EN
            m_err   <= 1'b0;
`endif
            state   <= ST_OUT;
          end
`ifdef AES_CTRL_TIMEOUT_EN
          else if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
            m_data  <= '0;
            m_err   <= 1'b1;
            m_valid <= 1'b1;
            state   <= ST_OUT;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
`endif
        end
        ST_OUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            busy    <= 1'b0;
            state   <= ST_IDLE;
            if (!m_err) begin
              blk_count <= blk_count + CNT_W'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_core_ctrl.sv
// tb_aes_core_ctrl: directed bench with a fixed-latency (4) XOR core model.
module tb_aes_core_ctrl;

  localparam logic [127:0] MASK_ENC = {16{8'h11}};
  localparam logic [127:0] MASK_DEC = {16{8'h22}};

  logic         clk = 1'b0;
  logic         reset;
  logic         s_valid;
  logic         s_ready;
  logic [127:0] s_data;
  logic         s_enc_dec;
  logic         core_start;
  logic         core_enc_dec;
  logic [127:0] core_data_in;
  logic [127:0] core_data_out;
  logic         core_done;
  logic         m_valid;
  logic         m_ready;
  logic [127:0] m_data;
  logic         m_err;
  logic         busy;
  logic [3:0]   blk_count;

  int n_tests = 0;
  int n_fail  = 0;

  aes_core_ctrl #(
    .CNT_W(4)
`ifdef AES_CTRL_TIMEOUT_EN
    , .TIMEOUT_CYC(8)
`endif
  ) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_enc_dec(s_enc_dec),
    .core_start(core_start), .core_enc_dec(core_enc_dec), .core_data_in(core_data_in),
    .core_data_out(core_data_out), .core_done(core_done),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_err(m_err),
    .busy(busy), .blk_count(blk_count)
  );

  always #5 clk = ~clk;

  // Core model: start is sampled at an edge, and done pulses for the cycle sampled 4 edges later.
  // The model is deliberately not reset, so that a done from a discarded block still arrives.
  logic [2:0] lat_cnt = 3'd0;
  logic       core_en = 1'b1;
  always_ff @(posedge clk) begin
    if (core_start && core_en) lat_cnt <= 3'd4;
    else if (lat_cnt != 3'd0)  lat_cnt <= lat_cnt - 3'd1;
  end
  assign core_done     = (lat_cnt == 3'd1);
  assign core_data_out = core_data_in ^ (core_enc_dec ? MASK_DEC : MASK_ENC);

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Sends one block with m_ready=1, checks the result, and consumes it.
  task automatic run_block(input logic [127:0] d, input logic ed, input string tag);
    logic [127:0] exp;
    int k;
    exp = d ^ (ed ? MASK_DEC : MASK_ENC);
    s_valid = 1'b1; s_data = d; s_enc_dec = ed; m_ready = 1'b1;
    tick();
    s_valid = 1'b0;
    k = 0;
    while (!m_valid && k < 40) begin tick(); k++; end
    if (!m_valid) check({tag, " wait m_valid"}, 128'd0, 128'd1);
    else          check(tag, m_data, exp);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, idx, res, cyc;
    int acc_cyc[3];
    logic [127:0] blk[3];
    logic acc_now;
    reset = 1'b1; s_valid = 1'b0; s_data = '0; s_enc_dec = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    tick(); tick();

    // Reset values
    check("rst s_ready", 128'(s_ready), 128'd0);
    check("rst core_start", 128'(core_start), 128'd0);
    check("rst core_enc_dec", 128'(core_enc_dec), 128'd0);
    check("rst core_data_in", core_data_in, 128'd0);
    check("rst m_valid", 128'(m_valid), 128'd0);
    check("rst m_data", m_data, 128'd0);
    check("rst m_err", 128'(m_err), 128'd0);
    check("rst busy", 128'(busy), 128'd0);
    check("rst blk_count", 128'(blk_count), 128'd0);
    reset = 1'b0;
    #1 check("post-rst s_ready", 128'(s_ready), 128'd1);

    // Encrypt zero block, timing of the start pulse and of m_valid
    s_valid = 1'b1; s_data = '0; s_enc_dec = 1'b0; m_ready = 1'b1;
    tick();
    s_valid = 1'b0;
    check("enc core_start on", 128'(core_start), 128'd1);
    check("enc s_ready low", 128'(s_ready), 128'd0);
    check("enc busy", 128'(busy), 128'd1);
    tick();
    check("enc core_start off", 128'(core_start), 128'd0);
    k = 2;
    while (!m_valid && k < 20) begin tick(); k++; end
    check("enc latency", 128'(k), 128'd6);
    check("enc m_data", m_data, {16{8'h11}});
    check("enc m_err", 128'(m_err), 128'd0);
    tick();
    check("enc m_valid drop", 128'(m_valid), 128'd0);
    check("enc blk_count", 128'(blk_count), 128'd1);
    check("enc s_ready back", 128'(s_ready), 128'd1);

    // Decrypt with downstream stalled for 10 cycles
    s_valid = 1'b1; s_data = {16{8'hFF}}; s_enc_dec = 1'b1; m_ready = 1'b0;
    tick();
    s_valid = 1'b0;
    k = 0;
    while (!m_valid && k < 20) begin tick(); k++; end
    check("dec m_valid", 128'(m_valid), 128'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("dec hold m_valid", 128'(m_valid), 128'd1);
      check("dec hold m_data", m_data, {16{8'hDD}});
      check("dec hold s_ready", 128'(s_ready), 128'd0);
    end
    m_ready = 1'b1;
    tick();
    check("dec m_valid drop", 128'(m_valid), 128'd0);
    check("dec blk_count", 128'(blk_count), 128'd2);

    // Three back-to-back blocks with s_valid held high
    blk[0] = 128'h1; blk[1] = 128'h2; blk[2] = 128'h3;
    idx = 0; res = 0; cyc = 0;
    s_valid = 1'b1; s_data = blk[0]; s_enc_dec = 1'b0; m_ready = 1'b1;
    while (res < 3 && cyc < 60) begin
      acc_now = s_valid && s_ready;
      if (m_valid && m_ready) begin
        check("b2b m_data", m_data, blk[res] ^ MASK_ENC);
        res++;
      end
      tick();
      cyc++;
      if (acc_now) begin
        acc_cyc[idx] = cyc;
        idx++;
        if (idx < 3) s_data = blk[idx];
        else         s_valid = 1'b0;
      end
    end
    check("b2b results", 128'(res), 128'd3);
    check("b2b spacing 0-1", 128'(acc_cyc[1] - acc_cyc[0]), 128'd7);
    check("b2b spacing 1-2", 128'(acc_cyc[2] - acc_cyc[1]), 128'd7);
    tick();
    check("b2b blk_count", 128'(blk_count), 128'd5);

    // Reset while waiting on the core, then ignore the stale done
    s_valid = 1'b1; s_data = 128'h5; s_enc_dec = 1'b0;
    tick();
    s_valid = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    check("midrst core_start", 128'(core_start), 128'd0);
    check("midrst core_data_in", core_data_in, 128'd0);
    check("midrst m_valid", 128'(m_valid), 128'd0);
    check("midrst busy", 128'(busy), 128'd0);
    check("midrst blk_count", 128'(blk_count), 128'd0);
    check("midrst s_ready", 128'(s_ready), 128'd0);
    reset = 1'b0;
    tick(); tick();
    check("stale m_valid", 128'(m_valid), 128'd0);
    check("stale busy", 128'(busy), 128'd0);
    check("stale m_data", m_data, 128'd0);
    check("stale s_ready", 128'(s_ready), 128'd1);
    run_block(128'hABCD, 1'b0, "post-rst block");
    check("post-rst blk_count", 128'(blk_count), 128'd1);

    // Counter wrap: 15 more blocks give 16 total completions
    for (int i = 0; i < 14; i++) run_block(128'(i), i[0], "wrap block");
    check("pre-wrap blk_count", 128'(blk_count), 128'd15);
    run_block({16{8'h5A}}, 1'b1, "wrap last");
    check("wrap blk_count", 128'(blk_count), 128'd0);

`ifdef AES_CTRL_TIMEOUT_EN
    // Core never answers, so the block times out after 8 WAIT cycles
    core_en = 1'b0;
    s_valid = 1'b1; s_data = {16{8'h77}}; s_enc_dec = 1'b0; m_ready = 1'b0;
    tick();
    s_valid = 1'b0;
    k = 1;
    while (!m_valid && k < 40) begin tick(); k++; end
    check("tmo latency", 128'(k), 128'd10);
    check("tmo m_err", 128'(m_err), 128'd1);
    check("tmo m_data", m_data, 128'd0);
    m_ready = 1'b1;
    tick();
    check("tmo m_valid drop", 128'(m_valid), 128'd0);
    check("tmo blk_count", 128'(blk_count), 128'd0);
    core_en = 1'b1;
    run_block(128'h9, 1'b0, "post-tmo block");
    check("post-tmo blk_count", 128'(blk_count), 128'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
